// File: rtl/ccr_unit_pkg.sv
// Shared ALU opcode encodings and CCR bit layout for the condition code unit.
package ccr_unit_pkg;

  localparam int unsigned CCR_W = 4;

  localparam logic [4:0] ALU_NOP = 5'h00;
  localparam logic [4:0] ALU_JZ  = 5'h10;
  localparam logic [4:0] ALU_JN  = 5'h11;
  localparam logic [4:0] ALU_JC  = 5'h12;
  localparam logic [4:0] ALU_JMP = 5'h13;
  localparam logic [4:0] ALU_RTI = 5'h14;

  localparam int unsigned CCR_ZF = 0;
  localparam int unsigned CCR_CF = 1;
  localparam int unsigned CCR_OF = 2;
  localparam int unsigned CCR_NF = 3;

  function automatic logic [CCR_W-1:0] pack_ccr(input logic nf, input logic of,
                                                input logic cf, input logic zf);
    logic [CCR_W-1:0] v;
    v         = '0;
    v[CCR_NF] = nf;
    v[CCR_OF] = of;
    v[CCR_CF] = cf;
    v[CCR_ZF] = zf;
    return v;
  endfunction

endpackage

// File: rtl/ccr_unit_stack.sv
// LIFO of CCR snapshots taken on interrupt entry; a same-cycle pop and push
// is applied pop first, so the top entry is replaced and depth is unchanged.
module ccr_snapshot_stack
  import ccr_unit_pkg::*;
#(
  parameter int unsigned FreezeDepth = 2,
  parameter int unsigned DepthW      = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [CCR_W-1:0]  push_data_i,
  output logic [CCR_W-1:0]  top_o,
  output logic [DepthW-1:0] depth_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [CCR_W-1:0]  mem_q [FreezeDepth];
  logic [CCR_W-1:0]  mem_d [FreezeDepth];
  logic [DepthW-1:0] depth_q, depth_d, depth_pop;

  always_comb begin
    mem_d     = mem_q;
    depth_pop = depth_q;
    if (pop_i && (depth_q != '0)) depth_pop = depth_q - 1'b1;
    depth_d = depth_pop;
    // A push into a full stack (after any pop) is dropped.
    if (push_i && (depth_pop != DepthW'(FreezeDepth))) begin
      for (int i = 0; i < int'(FreezeDepth); i++) begin
        if (depth_pop == DepthW'(i)) mem_d[i] = push_data_i;
      end
      depth_d = depth_pop + 1'b1;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < int'(FreezeDepth); i++) begin
      if (depth_q == DepthW'(i + 1)) top_o = mem_q[i];
    end
  end

  assign depth_o = depth_q;
  assign full_o  = (depth_q == DepthW'(FreezeDepth));
  assign empty_o = (depth_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      for (int i = 0; i < int'(FreezeDepth); i++) mem_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// Condition code register with interrupt snapshot stack and branch decision,
// sitting on the far side of the EX-stage ALU flag interface.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int unsigned FREEZE_DEPTH = 2,
  parameter int unsigned DEPTH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         aluSignals,
  input  logic               exValid,
  input  logic               stall,
  input  logic               zeroFlagIn,
  input  logic               carryFlagIn,
  input  logic               overFlowFlagIn,
  input  logic               negativeFlagIn,
  input  logic               intEnter,
  output logic               zeroFlag,
  output logic               carryFlag,
  output logic               overFlowFlag,
  output logic               negativeFlag,
  output logic [CCR_W-1:0]   ccr,
  output logic [CCR_W-1:0]   freezedCCR,
  output logic               jumpTaken,
  output logic [DEPTH_W-1:0] isrDepth,
  output logic               stackOverflow,
  output logic               stackUnderflow
);

  logic [CCR_W-1:0] ccr_q, ccr_d;
  logic             pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             commit, pop, push, int_eff;
  logic             stk_full, stk_empty;
  logic             jump;

  assign commit  = exValid & ~stall;
  assign pop     = commit & (aluSignals == ALU_RTI);
  assign int_eff = intEnter | pending_q;
  assign push    = int_eff & ~stall;

  always_comb begin
    ccr_d = ccr_q;
    if (commit) ccr_d = pack_ccr(negativeFlagIn, overFlowFlagIn, carryFlagIn, zeroFlagIn);
    // An interrupt seen during a stall waits for the first unstalled cycle.
    pending_d = stall ? int_eff : 1'b0;
    ovf_d     = ovf_q | (push & stk_full & ~pop);
    unf_d     = unf_q | (pop & stk_empty);
  end

  always_comb begin
    jump = 1'b0;
    if (exValid) begin
      case (aluSignals)
        ALU_JZ:  jump = ccr_q[CCR_ZF];
        ALU_JN:  jump = ccr_q[CCR_NF];
        ALU_JC:  jump = ccr_q[CCR_CF];
        ALU_JMP: jump = 1'b1;
        default: jump = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccr_q     <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      ccr_q     <= ccr_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // The snapshot is the CCR value being written on this same edge.
  ccr_snapshot_stack #(
    .FreezeDepth (FREEZE_DEPTH),
    .DepthW      (DEPTH_W)
  ) u_stack (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (ccr_d),
    .top_o       (freezedCCR),
    .depth_o     (isrDepth),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  assign ccr            = ccr_q;
  assign zeroFlag       = ccr_q[CCR_ZF];
  assign carryFlag      = ccr_q[CCR_CF];
  assign overFlowFlag   = ccr_q[CCR_OF];
  assign negativeFlag   = ccr_q[CCR_NF];
  assign jumpTaken      = jump;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops and compares them.
module tb_ccr_unit;
  import ccr_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] aluSignals = '0;
  logic       exValid = 1'b0, stall = 1'b0, intEnter = 1'b0;
  logic       zeroFlagIn = 1'b0, carryFlagIn = 1'b0, overFlowFlagIn = 1'b0;
  logic       negativeFlagIn = 1'b0;
  logic       zeroFlag, carryFlag, overFlowFlag, negativeFlag;
  logic [3:0] ccr, freezedCCR;
  logic       jumpTaken;
  logic [1:0] isrDepth;
  logic       stackOverflow, stackUnderflow;

  ccr_unit #(.FREEZE_DEPTH(2), .DEPTH_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .aluSignals     (aluSignals),
    .exValid        (exValid),
    .stall          (stall),
    .zeroFlagIn     (zeroFlagIn),
    .carryFlagIn    (carryFlagIn),
    .overFlowFlagIn (overFlowFlagIn),
    .negativeFlagIn (negativeFlagIn),
    .intEnter       (intEnter),
    .zeroFlag       (zeroFlag),
    .carryFlag      (carryFlag),
    .overFlowFlag   (overFlowFlag),
    .negativeFlag   (negativeFlag),
    .ccr            (ccr),
    .freezedCCR     (freezedCCR),
    .jumpTaken      (jumpTaken),
    .isrDepth       (isrDepth),
    .stackOverflow  (stackOverflow),
    .stackUnderflow (stackUnderflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jump;
    logic [3:0] ccr;
    logic [3:0] frz;
    logic [1:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: CCR as a nibble, snapshots as a plain queue.
  logic [3:0] m_ccr;
  logic [3:0] m_stk[$];
  logic       m_pend, m_ovf, m_unf;
  localparam int MaxDepth = 2;

  function automatic void m_reset();
    m_ccr  = 4'b0000;
    m_stk  = {};
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  function automatic logic [3:0] m_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 4'b0000;
  endfunction

  function automatic logic m_jump(input logic [4:0] op, input logic ev);
    if (!ev) return 1'b0;
    if (op == ALU_JZ) return m_ccr[0];
    if (op == ALU_JN) return m_ccr[3];
    if (op == ALU_JC) return m_ccr[1];
    if (op == ALU_JMP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_apply(input logic [4:0] op, input logic ev, input logic st,
                                  input logic ie, input logic [3:0] fl);
    logic commit;
    logic [3:0] nxt;
    commit = ev && !st;
    if (commit && op == ALU_RTI) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_unf = 1'b1;
    end
    nxt = commit ? fl : m_ccr;
    if (st) begin
      m_pend = m_pend | ie;
    end else begin
      if (ie || m_pend) begin
        if (m_stk.size() < MaxDepth) m_stk.push_back(nxt);
        else m_ovf = 1'b1;
      end
      m_pend = 1'b0;
    end
    m_ccr = nxt;
  endfunction

  function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
  endfunction

  // One cycle of stimulus; r=0 asserts reset just after the edge.
  task automatic step(input logic r, input logic [4:0] op, input logic ev, input logic st,
                      input logic ie, input logic [3:0] fl);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r;
    aluSignals = op;
    exValid = ev;
    stall = st;
    intEnter = ie;
    {negativeFlagIn, overFlowFlagIn, carryFlagIn, zeroFlagIn} = fl;
    if (!r) m_reset();
    e.jump  = m_jump(op, ev);
    e.ccr   = m_ccr;
    e.frz   = m_top();
    e.depth = 2'(m_stk.size());
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
    if (r) m_apply(op, ev, st, ie, fl);
  endtask

  task automatic idle();
    step(1'b1, ALU_NOP, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic commit_flags(input logic [3:0] fl);
    step(1'b1, ALU_NOP, 1'b1, 1'b0, 1'b0, fl);
  endtask

  task automatic rti(input logic ie);
    step(1'b1, ALU_RTI, 1'b1, 1'b0, ie, m_top());
  endtask

  task automatic irq();
    step(1'b1, ALU_NOP, 1'b0, 1'b0, 1'b1, 4'b0000);
  endtask

  // Monitor: outputs are stable at the falling edge, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("jumpTaken", {3'b0, jumpTaken}, {3'b0, e.jump});
        chk("ccr", ccr, e.ccr);
        chk("flags", {negativeFlag, overFlowFlag, carryFlag, zeroFlag}, e.ccr);
        chk("freezedCCR", freezedCCR, e.frz);
        chk("isrDepth", {2'b0, isrDepth}, {2'b0, e.depth});
        chk("stackOverflow", {3'b0, stackOverflow}, {3'b0, e.ovf});
        chk("stackUnderflow", {3'b0, stackUnderflow}, {3'b0, e.unf});
      end
    end
  end

  initial begin
    logic [4:0] op;
    logic [3:0] fl;
    int         wait_cnt;
    m_reset();
    step(1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle();

    // Flag capture, then stall must hold the CCR.
    commit_flags(4'b1010);
    step(1'b1, ALU_NOP, 1'b1, 1'b1, 1'b0, 4'b0101);
    idle();

    // Jump decisions from CCR = 0001; ALU leaves flags as they are.
    commit_flags(4'b0001);
    step(1'b1, ALU_JZ, 1'b1, 1'b0, 1'b0, 4'b0001);
    step(1'b1, ALU_JN, 1'b1, 1'b0, 1'b0, 4'b0001);
    step(1'b1, ALU_JC, 1'b1, 1'b0, 1'b0, 4'b0001);
    step(1'b1, ALU_JMP, 1'b1, 1'b0, 1'b0, 4'b0001);
    step(1'b1, ALU_JZ, 1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b1, ALU_JMP, 1'b0, 1'b0, 1'b0, 4'b0001);

    // Interrupt / RTI round trip.
    commit_flags(4'b1010);
    irq();
    commit_flags(4'b0001);
    rti(1'b0);
    idle();

    // Nesting and overflow, then unwinding.
    commit_flags(4'b0011);
    irq();
    commit_flags(4'b0100);
    irq();
    irq();
    rti(1'b0);
    rti(1'b0);
    idle();

    // Interrupt arriving during a stall is held pending.
    commit_flags(4'b0110);
    step(1'b1, ALU_NOP, 1'b0, 1'b1, 1'b1, 4'b0000);
    step(1'b1, ALU_NOP, 1'b0, 1'b1, 1'b0, 4'b0000);
    idle();
    idle();

    // Fresh reset, then RTI on an empty stack.
    step(1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0, 4'b0000);
    commit_flags(4'b1111);
    rti(1'b0);
    idle();

    // RTI and interrupt together at depth 1.
    commit_flags(4'b1100);
    irq();
    commit_flags(4'b0010);
    rti(1'b1);
    idle();

    // Reset in the middle of an ISR, checked before any clock edge.
    step(1'b0, ALU_JMP, 1'b1, 1'b0, 1'b0, 4'b1111);
    idle();

    // Randomized traffic with periodic resets so the sticky flags re-arm.
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 249) begin
        step(1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0, 4'b0000);
      end else begin
        case ($urandom_range(0, 9))
          0, 1:    op = ALU_RTI;
          2:       op = ALU_JZ;
          3:       op = ALU_JN;
          4:       op = ALU_JC;
          5:       op = ALU_JMP;
          default: op = 5'($urandom_range(0, 7));
        endcase
        fl = 4'($urandom_range(0, 15));
        if (op == ALU_RTI && $urandom_range(0, 3) != 0) fl = m_top();
        step(1'b1, op, ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 6) == 0), fl);
      end
    end
    idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
